// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the RV32M sequencer and the ALU decoder.
//   XLEN       operand/result width (32 only)
//   DIV_STEPS  restoring-divide iterations
//   OP_*       SELECT codes for the M-extension ops
//   state_t    sequencer state encoding
package muldiv_pkg;
    localparam int XLEN      = 32;
    localparam int DIV_STEPS = 32;

    localparam logic [4:0] OP_MUL    = 5'b01000;
    localparam logic [4:0] OP_MULH   = 5'b01001;
    localparam logic [4:0] OP_MULHSU = 5'b01010;
    localparam logic [4:0] OP_MULHU  = 5'b01011;
    localparam logic [4:0] OP_DIV    = 5'b01100;
    localparam logic [4:0] OP_DIVU   = 5'b01101;
    localparam logic [4:0] OP_REM    = 5'b01110;
    localparam logic [4:0] OP_REMU   = 5'b01111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    // Magnitude of v when treated as signed; the most negative value maps
    // to itself, which is still the right unsigned magnitude.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction
endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// div_step: one combinational restoring-division step.
//   rem, quo      current partial remainder / quotient (dividend bits shift out of quo)
//   divisor       unsigned divisor
//   rem_next      remainder after shift and trial subtract
//   quo_next      quotient after shift, LSB set when the subtract succeeded
module div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic            borrow;

    always_comb begin
        // Shifted remainder can need XLEN+1 bits; the extra top bit of diff
        // is the borrow of the trial subtract.
        shifted  = {rem, quo[XLEN-1]};
        diff     = {1'b0, shifted} - {2'b00, divisor};
        borrow   = diff[XLEN+1];
        rem_next = borrow ? XLEN'(shifted) : XLEN'(diff);
        quo_next = {quo[XLEN-2:0], ~borrow};
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M unit for the EX stage.
//   CLK, RESET      clock, synchronous active-high reset
//   START, SELECT   issue request and op code (01xxx accepted when not busy)
//   DATA1, DATA2    rs1 / rs2 operands, latched at issue
//   FLUSH           abort the in-flight op, no result
//   BUSY            op in flight (MUL / DIV / FIX states)
//   RESULT_VALID    one-cycle completion strobe
//   RESULT          last completed result, held between completions
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      SELECT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            RESULT_VALID,
    output logic [XLEN-1:0] RESULT
);
    state_t state, state_nxt;

    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
    logic [5:0]      cnt_q;
    logic            neg_q_q, neg_r_q;
    logic [XLEN-1:0] result_q;

    // Issue decode, evaluated on the live inputs
    logic            in_busy, start_ok, in_signed, in_special;
    logic [XLEN-1:0] special_res;

    assign in_busy  = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
    assign start_ok = START && !in_busy && !FLUSH && (SELECT[4:3] == 2'b01);

    always_comb begin
        in_signed   = !SELECT[0];
        in_special  = 1'b0;
        special_res = '0;
        if (DATA2 == '0) begin
            in_special  = 1'b1;
            special_res = SELECT[1] ? DATA1 : '1;
        end else if (in_signed && DATA1 == 32'h8000_0000 && DATA2 == 32'hFFFF_FFFF) begin
            in_special  = 1'b1;
            special_res = SELECT[1] ? '0 : 32'h8000_0000;
        end
    end

    // Multiply: extend each operand to 33 bits per op, keep the low 64
    // bits of the 66-bit product (the top two bits never reach RESULT).
    logic               a_sgn, b_sgn;
    logic signed [32:0] ax, bx;
    logic [63:0]        prod;
    logic [XLEN-1:0]    mul_res;

    always_comb begin
        a_sgn   = (op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10);
        b_sgn   = (op_q[1:0] == 2'b01);
        ax      = {a_sgn & a_q[XLEN-1], a_q};
        bx      = {b_sgn & b_q[XLEN-1], b_q};
        prod    = 64'(66'(ax) * 66'(bx));
        mul_res = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end

    // Divide datapath
    logic [XLEN-1:0] rem_nxt, quo_nxt, fix_res;

    div_step u_div_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .rem_next (rem_nxt),
        .quo_next (quo_nxt)
    );

    always_comb begin
        if (op_q[1]) fix_res = neg_r_q ? -rem_q : rem_q;
        else         fix_res = neg_q_q ? -quo_q : quo_q;
    end

    // FSM: state register
    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if (FLUSH) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    state_nxt = ST_IDLE;
                    if (start_ok) begin
                        if (!SELECT[2])     state_nxt = ST_MUL;
                        else if (in_special) state_nxt = ST_DONE;
                        else                 state_nxt = ST_DIV;
                    end
                end
                ST_MUL:  state_nxt = ST_DONE;
                ST_DIV:  state_nxt = (cnt_q == 6'd1) ? ST_FIX : ST_DIV;
                ST_FIX:  state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        BUSY         = in_busy;
        RESULT_VALID = (state == ST_DONE);
        RESULT       = result_q;
    end

    // Operand, iteration and result registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
        end else if (start_ok) begin
            op_q <= SELECT[2:0];
            a_q  <= DATA1;
            b_q  <= DATA2;
            if (SELECT[2]) begin
                if (in_special) begin
                    result_q <= special_res;
                end else begin
                    rem_q   <= '0;
                    quo_q   <= mag(DATA1, in_signed);
                    dvsr_q  <= mag(DATA2, in_signed);
                    cnt_q   <= 6'(DIV_STEPS);
                    neg_q_q <= in_signed & (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
                    neg_r_q <= in_signed & DATA1[XLEN-1];
                end
            end
        end else if (!FLUSH) begin
            case (state)
                ST_MUL: result_q <= mul_res;
                ST_DIV: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q - 6'd1;
                end
                ST_FIX: result_q <= fix_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET, START, FLUSH;
    logic [4:0]  SELECT;
    logic [31:0] DATA1, DATA2;
    logic        BUSY, RESULT_VALID;
    logic [31:0] RESULT;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .START        (START),
        .SELECT       (SELECT),
        .DATA1        (DATA1),
        .DATA2        (DATA2),
        .FLUSH        (FLUSH),
        .BUSY         (BUSY),
        .RESULT_VALID (RESULT_VALID),
        .RESULT       (RESULT)
    );

    always #5 CLK = ~CLK;

    // Reference: RV32M semantics with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_res(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (sel)
            OP_MUL:    begin p = sa * sb; return 32'(p); end
            OP_MULH:   begin p = sa * sb; return 32'(p >>> 32); end
            OP_MULHSU: begin p = sa * ub; return 32'(p >>> 32); end
            OP_MULHU:  begin p = ua * ub; return 32'(p >> 32); end
            OP_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            OP_REM:    begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default:   return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    // Cycles from the accepting edge to the RESULT_VALID cycle.
    function automatic int ref_lat(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (!sel[2]) return 2;
        if (b == 0) return 1;
        if (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issue one op, scramble the inputs after acceptance, then check BUSY
    // and RESULT_VALID every cycle up to and including the completion cycle.
    task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string tag);
        START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
        step();
        START = 1'b0; SELECT = 5'($urandom); DATA1 = $urandom; DATA2 = $urandom;
        for (int k = 1; k <= lat; k++) begin
            chk({tag, "/busy"},  32'(BUSY),         32'(k < lat));
            chk({tag, "/valid"}, 32'(RESULT_VALID), 32'(k == lat));
            if (k == lat) chk({tag, "/result"}, RESULT, exp);
            else          step();
        end
    endtask

    initial begin
        logic [4:0]  sel;
        logic [31:0] a, b;

        RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
        SELECT = '0; DATA1 = '0; DATA2 = '0;
        step(); step();
        chk("reset/busy",   32'(BUSY),         32'h0);
        chk("reset/valid",  32'(RESULT_VALID), 32'h0);
        chk("reset/result", RESULT,            32'h0);
        RESET = 1'b0;
        step();

        run_op(OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, "mul");
        step();
        run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mulhu");
        run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2, "mulh");
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, "mulhsu");
        step();
        run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div");
        run_op(OP_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem");
        run_op(OP_DIVU,   32'd100,       32'd7, 32'd14,        34, "divu");
        run_op(OP_REMU,   32'd100,       32'd7, 32'd2,         34, "remu");
        step();
        run_op(OP_DIVU,   32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu0");
        step();
        run_op(OP_REM,    32'd5, 32'd0, 32'd5,         1, "rem0");
        step();
        run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "divovf");
        step();
        run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, "removf");
        step();

        // Invalid SELECT is ignored and RESULT holds.
        START = 1'b1; SELECT = 5'b00000; DATA1 = 32'd9; DATA2 = 32'd3;
        step();
        START = 1'b0;
        chk("badsel/busy",  32'(BUSY),         32'h0);
        chk("badsel/valid", 32'(RESULT_VALID), 32'h0);
        step();
        chk("badsel/busy2", 32'(BUSY),         32'h0);
        chk("badsel/hold",  RESULT,            32'h0);

        // FLUSH beats a simultaneous START.
        START = 1'b1; FLUSH = 1'b1; SELECT = OP_DIVU; DATA1 = 32'd50; DATA2 = 32'd3;
        step();
        START = 1'b0; FLUSH = 1'b0;
        chk("flushstart/busy",  32'(BUSY),         32'h0);
        chk("flushstart/valid", 32'(RESULT_VALID), 32'h0);

        // Back-to-back: MUL issued during the DONE cycle of a divide.
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, "b2b_div");
        run_op(OP_MUL,  32'd6,   32'd7, 32'd42, 2,  "b2b_mul");
        step();

        // Abort with FLUSH at t+10.
        START = 1'b1; SELECT = OP_DIV; DATA1 = 32'hFFFF_FFF9; DATA2 = 32'd2;
        step();
        START = 1'b0;
        repeat (9) step();
        chk("flush/busy_t10", 32'(BUSY), 32'h1);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        chk("flush/busy_t11", 32'(BUSY), 32'h0);
        for (int c = 11; c <= 40; c++) begin
            chk("flush/valid", 32'(RESULT_VALID), 32'h0);
            step();
        end
        chk("flush/result_hold", RESULT, 32'd42);

        // Abort with RESET at t+10.
        START = 1'b1; SELECT = OP_DIVU; DATA1 = 32'd1000; DATA2 = 32'd3;
        step();
        START = 1'b0;
        repeat (9) step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("rstabort/busy",   32'(BUSY),         32'h0);
        chk("rstabort/valid",  32'(RESULT_VALID), 32'h0);
        chk("rstabort/result", RESULT,            32'h0);
        step();
        chk("rstabort/busy2",  32'(BUSY),         32'h0);

        // Randomized ops against the reference model.
        for (int n = 0; n < 48; n++) begin
            sel = 5'(8 + $urandom_range(0, 7));
            a   = pick();
            b   = pick();
            run_op(sel, a, b, ref_res(sel, a, b), ref_lat(sel, a, b), "rand");
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M operations (SELECT codes 01000–01111) in the EX stage. The combinational ALU keeps the single-cycle RV32I ops. This block registers M-extension operands, runs a 2-cycle multiply or a 32-iteration restoring divide, and holds BUSY high to stall the pipeline. It returns RESULT with a one-cycle RESULT_VALID strobe and supports abort on pipeline flush.

## Interface
- XLEN, 32: operand/result width; the only supported value.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  issue request; sampled only when BUSY=0.
- SELECT  in  5  op code: 01000 MUL, 01001 MULH, 01010 MULHSU, 01011 MULHU, 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU.
- DATA1  in  32  rs1 operand (dividend / multiplicand).
- DATA2  in  32  rs2 operand (divisor / multiplier).
- FLUSH  in  1  abort the in-flight op; no result is produced.
- BUSY  out  1  op in flight; the pipeline stalls EX while high.
- RESULT_VALID  out  1  one-cycle strobe; RESULT is valid this cycle.
- RESULT  out  32  result; holds its last value until the next completion.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- Start condition: START=1, BUSY=0 and SELECT[4:3]=01.
  - On start, latch SELECT, DATA1 and DATA2 into internal registers.
  - START with any other SELECT is ignored; the state is unchanged.
- IDLE/DONE → MUL (SELECT[2]=0).
  - MUL computes a 66-bit product: operands are sign- or zero-extended to 33 bits per op (MULH s×s, MULHSU s×u, MULHU u×u).
  - MUL → DONE.
  - MUL returns product[31:0]; the other three return product[63:32].
- IDLE/DONE → DIV (SELECT[2]=1, normal case).
  - Take magnitudes for the signed ops (DIV, REM).
  - Record negate-quotient = sign(DATA1)^sign(DATA2) and negate-remainder = sign(DATA1).
  - Load a 6-bit counter with 32.
- DIV: one restoring step per cycle.
  - Shift {rem, quo} left 1 bit.
  - Trial-subtract the divisor from rem; on no borrow, keep the difference and set quo[0]=1.
  - Decrement the counter; at counter=1 go to FIX.
- FIX: apply the sign corrections, select quotient (DIV/DIVU) or remainder (REM/REMU), then → DONE.
- Special cases go IDLE/DONE → DONE directly with no iteration:
  - Divisor 0: quotient 0xFFFFFFFF; remainder = DATA1.
  - Signed overflow (DATA1=0x80000000, DATA2=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
- DONE: RESULT_VALID=1, BUSY=0.
  - A start in DONE is accepted (back-to-back issue).
  - Otherwise DONE → IDLE.
- FLUSH=1 in any state → IDLE next cycle.
  - RESULT_VALID stays 0 and RESULT is not updated.
  - A START in the same cycle is ignored; FLUSH wins.
- RESET: state IDLE, RESULT=0, RESULT_VALID=0, BUSY=0, counter=0. Reset mid-op discards the op.

## Timing
- Start accepted at edge t.
- MUL: BUSY=1 in cycle t+1; RESULT_VALID=1 in cycle t+2.
- Divide, normal: BUSY=1 in cycles t+1..t+33 (DIV ×32, FIX ×1); RESULT_VALID=1 in cycle t+34.
- Divide, special case: RESULT_VALID=1 in cycle t+1; BUSY never rises.
- BUSY is a registered output: BUSY = (state ∈ {MUL, DIV, FIX}).
- RESULT_VALID = (state==DONE); RESULT updates on the edge entering DONE.
- Operand changes on DATA1/DATA2/SELECT after the start have no effect.

## Structure
- Shared package muldiv_pkg holds:
  - The SELECT localparams: OP_MUL…OP_REMU.
  - The state encoding: IDLE, MUL, DIV, FIX, DONE.
  - DIV_STEPS=32.
- The ALU decoder imports the same OP_* constants.
- One sub-module, div_step: combinational single restoring step. Inputs rem, quo, divisor; outputs next rem and quo. It is instantiated once in the DIV state.
- The FSM, operand registers, multiply and sign fixup stay in muldiv_sequencer.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), START at t → RESULT=0xFFFFFFEB, RESULT_VALID only in t+2, BUSY high only in t+1.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD at t+34, BUSY high t+1..t+33; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each valid at t+1 with BUSY=0 throughout:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Abort: start DIV, FLUSH at t+10 → state IDLE at t+11, no RESULT_VALID through t+40, RESULT unchanged. Repeat with RESET at t+10 → all outputs 0.
- Back-to-back: START MUL held during DONE of a prior DIV → second result valid two cycles later. START with SELECT=00000 → ignored, BUSY stays 0.
